// File: rtl/toy_fetch_stage.sv
// TOY instruction-fetch stage: drives the instruction-memory address, registers
// the returned word into IR and hands it to decode over a valid/ready handshake.
module toy_fetch_stage #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter logic [3:0]  HALT_OP  = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [11:0] imem_pc,
    input  logic [15:0] imem_inst,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
    output logic [15:0] ir,
    output logic [11:0] ir_pc,
    output logic        ir_valid,
    input  logic        id_ready,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [11:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] count_q, count_d;
    logic        load;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        count_d    = count_q;
        load       = (state_q == S_FETCH) && !redirect && (!ir_valid_q || id_ready);

        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_FETCH;
            end
        end else if (redirect) begin
            // Flush from either FETCH or HALT; this also cancels a speculative halt.
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
            state_d    = S_FETCH;
        end else if (load) begin
            ir_d       = imem_inst;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
            if (imem_inst[15:12] == HALT_OP) begin
                state_d = S_HALT;
            end else begin
                pc_d = pc_q + 12'd1;
            end
        end else if (ir_valid_q && id_ready) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            count_q    <= count_d;
        end
    end

    assign imem_pc     = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = (state_q == S_HALT) && !ir_valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_toy_fetch_stage.sv
// Directed vector bench for toy_fetch_stage with a behavioural instruction memory.
module tb_toy_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, start, redirect, id_ready;
    logic [11:0] redirect_pc;
    logic [11:0] imem_pc, ir_pc;
    logic [15:0] imem_inst, ir, fetch_count;
    logic        ir_valid, halted;

    logic [15:0] mem [4096];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign imem_inst = mem[imem_pc];

    toy_fetch_stage #(.RESET_PC(12'h000), .HALT_OP(4'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem_pc     (imem_pc),
        .imem_inst   (imem_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .id_ready    (id_ready),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic        rst, st, rd;
        logic [11:0] rpc;
        logic        rdy;
        logic        chk_ir;
        logic [11:0] pc;
        logic [15:0] ir;
        logic [11:0] irpc;
        logic        v, h;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic chk_ir, input logic [11:0] e_pc,
                         input logic [15:0] e_ir, input logic [11:0] e_irpc,
                         input logic e_v, input logic e_h, input logic [15:0] e_cnt);
        logic bad;
        bad = (imem_pc !== e_pc) || (ir_valid !== e_v) || (halted !== e_h) ||
              (fetch_count !== e_cnt) || (chk_ir && ((ir !== e_ir) || (ir_pc !== e_irpc)));
        n_vec++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got pc=%h ir=%h ir_pc=%h v=%b h=%b cnt=%h, want pc=%h ir=%h ir_pc=%h v=%b h=%b cnt=%h (ir checked=%b)",
                     name, imem_pc, ir, ir_pc, ir_valid, halted, fetch_count,
                     e_pc, e_ir, e_irpc, e_v, e_h, e_cnt, chk_ir);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rd,
                         input logic [11:0] rpc, input logic rdy);
        @(negedge clk);
        reset = r; start = s; redirect = rd; redirect_pc = rpc; id_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = {4'h8, a[11:0]};
        mem[0] = 16'h1234;
        mem[1] = 16'h2345;
        mem[5] = 16'h0000;

        reset = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        //            rst   st    rd    rpc      rdy   chk   pc       ir        irpc     v     h     cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h001, 16'h1234, 12'h000, 1'b1, 1'b0, 16'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h002, 16'h2345, 12'h001, 1'b1, 1'b0, 16'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h002, 16'h2345, 12'h001, 1'b1, 1'b0, 16'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h002, 16'h2345, 12'h001, 1'b1, 1'b0, 16'd2};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h002, 16'h2345, 12'h001, 1'b1, 1'b0, 16'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h003, 16'h8002, 12'h002, 1'b1, 1'b0, 16'd3};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 12'h0A0, 1'b0, 1'b0, 12'h0A0, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd3};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h0A1, 16'h80A0, 12'h0A0, 1'b1, 1'b0, 16'd4};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 12'h004, 1'b1, 1'b0, 12'h004, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd4};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h005, 16'h8004, 12'h004, 1'b1, 1'b0, 16'd5};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h005, 16'h0000, 12'h005, 1'b1, 1'b0, 16'd6};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h005, 16'h0000, 12'h005, 1'b1, 1'b0, 16'd6};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h005, 16'h0000, 12'h000, 1'b0, 1'b1, 16'd6};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h005, 16'h0000, 12'h000, 1'b0, 1'b1, 16'd6};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h005, 16'h0000, 12'h000, 1'b0, 1'b1, 16'd6};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 12'h005, 1'b1, 1'b0, 12'h005, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd6};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h005, 16'h0000, 12'h005, 1'b1, 1'b0, 16'd7};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 12'h010, 1'b0, 1'b0, 12'h010, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd7};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h011, 16'h8010, 12'h010, 1'b1, 1'b0, 16'd8};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 12'hFFF, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd8};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 16'h8FFF, 12'hFFF, 1'b1, 1'b0, 16'd9};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h001, 16'h1234, 12'h000, 1'b1, 1'b0, 16'd10};
        vecs[24] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd0};
        vecs[25] = '{1'b0, 1'b0, 1'b1, 12'h123, 1'b1, 1'b1, 12'h000, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd0};

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].chk_ir, vecs[i].pc, vecs[i].ir,
                  vecs[i].irpc, vecs[i].v, vecs[i].h, vecs[i].cnt);
        end

        // Saturation of fetch_count: clear the halt word so fetch streams through every address.
        mem[5] = 16'h8005;
        drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b1);
        check("sat_start", 1'b0, 12'h000, 16'h0000, 12'h000, 1'b0, 1'b0, 16'd0);
        start = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 1'b1, 12'hFFE, 16'h8FFD, 12'hFFD, 1'b1, 1'b0, 16'hFFFE);
        @(posedge clk); #1;
        check("sat_ffff", 1'b1, 12'hFFF, 16'h8FFE, 12'hFFE, 1'b1, 1'b0, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", 1'b1, 12'h002, 16'h2345, 12'h001, 1'b1, 1'b0, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
